frame_buffer_ctrl: RTL and testbench

Sequences single-frame capture into the shared single-port frame RAM and arbitrates that RAM between the camera write port and the downstream pixel reader. It sits between the camera capture block and the 96x96 frame BRAM. It grants the RAM to the camera for exactly one complete frame. It then hands the RAM to the reader until the reader releases it.

---
 rtl/frame_buf_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 35 +++
 rtl/frame_buffer_ctrl.sv | 150 +++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types and default geometry for the frame buffer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_buf_pkg;

    localparam int ADDR_W_DEF       = 15;
    localparam int DATA_W_DEF       = 8;
    localparam int FRAME_PIXELS_DEF = 96 * 96;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        READY
    } fb_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, with registered rise/fall pulses.
// Latency: an input transition shows up as a one-cycle pulse 3 cycles later.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
//
// Ports: i_Clk, i_Rst (sync, active-high), i_Async (raw level),
//        o_Rise / o_Fall (one-cycle pulses on the synchronized level).
module sync_edge_det (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Async,
    output logic o_Rise,
    output logic o_Fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            o_Rise <= 1'b0;
            o_Fall <= 1'b0;
        end else begin
            meta   <= i_Async;
            sync   <= meta;
            sync_d <= sync;
            o_Rise <= sync & ~sync_d;
            o_Fall <= ~sync & sync_d;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Captures one camera frame into the single-port frame RAM, then hands the RAM to the reader.
// Latency: camera write -> RAM port 1 cycle; read request -> o_Rd_Valid 2+RD_LATENCY cycles.
// Backpressure: none; writes/reads outside their owning state are silently dropped.
//
// Ports: i_Clk/i_Rst (sync, active-high); i_Start/i_Continuous control arming;
//        i_VS raw vsync; i_Cam_* camera write port; i_Rd_En/i_Rd_Addr/i_Rd_Done reader;
//        o_RAM_* registered RAM port, i_RAM_Dout read data; o_Rd_Data/o_Rd_Valid read return;
//        o_Frame_Valid, o_Busy, o_Short_Frame, o_Frame_Count status.
module frame_buffer_ctrl
    import frame_buf_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int RD_LATENCY   = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic              i_Continuous,
    input  logic              i_VS,
    input  logic [ADDR_W-1:0] i_Cam_Addr,
    input  logic [DATA_W-1:0] i_Cam_Data,
    input  logic              i_Cam_WE,
    input  logic              i_Rd_En,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    input  logic              i_Rd_Done,
    output logic [ADDR_W-1:0] o_RAM_Addr,
    output logic [DATA_W-1:0] o_RAM_Din,
    output logic              o_RAM_WE,
    input  logic [DATA_W-1:0] i_RAM_Dout,
    output logic [DATA_W-1:0] o_Rd_Data,
    output logic              o_Rd_Valid,
    output logic              o_Frame_Valid,
    output logic              o_Busy,
    output logic              o_Short_Frame,
    output logic [7:0]        o_Frame_Count
);

    localparam int                CNT_W    = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    // One extra bit so the limit itself is representable for any ADDR_W.
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(FRAME_PIXELS);

    fb_state_t          state;
    logic [CNT_W-1:0]   wr_cnt;
    logic               vs_rise;
    logic               vs_fall;
    logic               cam_acc;
    logic               rd_acc;
    // Valid tag travelling alongside the RAM read; last stage feeds o_Rd_Valid.
    logic [RD_LATENCY:0] rd_pipe;

    sync_edge_det u_vs_sync (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Async (i_VS),
        .o_Rise  (vs_rise),
        .o_Fall  (vs_fall)
    );

    assign cam_acc = (state == CAPTURE) && i_Cam_WE && ({1'b0, i_Cam_Addr} < ADDR_LIM);
    assign rd_acc  = (state == READY) && i_Rd_En;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            o_Frame_Valid <= 1'b0;
            o_Busy        <= 1'b0;
            o_Short_Frame <= 1'b0;
            o_Frame_Count <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_Start) begin
                        state         <= WAIT_VS;
                        o_Busy        <= 1'b1;
                        o_Short_Frame <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        state  <= CAPTURE;
                        wr_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    // Completion wins over a coincident vsync rise: the frame is whole.
                    if (cam_acc && (wr_cnt == LAST_CNT)) begin
                        state         <= READY;
                        wr_cnt        <= wr_cnt + CNT_ONE;
                        o_Frame_Valid <= 1'b1;
                        o_Frame_Count <= o_Frame_Count + 8'd1;
                    end else begin
                        if (cam_acc) begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end
                        if (vs_rise) begin
                            state         <= WAIT_VS;
                            o_Short_Frame <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (i_Rd_Done) begin
                        state         <= i_Continuous ? WAIT_VS : IDLE;
                        o_Frame_Valid <= 1'b0;
                        o_Busy        <= i_Continuous;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port mux and read-return pipeline. A read accepted alongside
    // i_Rd_Done still drains through rd_pipe after the RAM is released.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_RAM_Addr <= '0;
            o_RAM_Din  <= '0;
            o_RAM_WE   <= 1'b0;
            rd_pipe    <= '0;
            o_Rd_Data  <= '0;
            o_Rd_Valid <= 1'b0;
        end else begin
            o_RAM_WE <= cam_acc;
            if (cam_acc) begin
                o_RAM_Addr <= i_Cam_Addr;
                o_RAM_Din  <= i_Cam_Data;
            end else if (rd_acc) begin
                o_RAM_Addr <= i_Rd_Addr;
            end
            if (RD_LATENCY > 0) begin
                rd_pipe <= {rd_pipe[RD_LATENCY-1:0], rd_acc};
            end else begin
                rd_pipe <= rd_acc;
            end
            o_Rd_Valid <= rd_pipe[RD_LATENCY];
            if (rd_pipe[RD_LATENCY]) begin
                o_Rd_Data <= i_RAM_Dout;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Randomized self-checking bench for frame_buffer_ctrl against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_buffer_ctrl;

    localparam int FP   = 9216;
    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int RDL  = 1;
    localparam int FP_S = 16;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_CAP   = 2;
    localparam int P_READY = 3;

    logic          clk = 1'b0;
    logic          rst, start, cont, vs, cam_we, rd_en, rd_done;
    logic [AW-1:0] cam_addr, rd_addr, ram_addr;
    logic [DW-1:0] cam_data, ram_din, ram_dout, rd_data;
    logic          ram_we, rd_valid, frame_valid, busy, short_frame;
    logic [7:0]    frame_count;

    // Small-frame instance used for the 256-frame wrap and continuous rearm.
    logic          s_start, s_cont, s_vs, s_we, s_done;
    logic [AW-1:0] s_addr, s_ram_addr;
    logic [DW-1:0] s_data, s_ram_din, s_rd_data;
    logic          s_ram_we, s_rd_valid, s_fv, s_busy, s_short;
    logic [7:0]    s_fc;

    always #5 clk = ~clk;

    frame_buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP), .RD_LATENCY(RDL)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Continuous(cont), .i_VS(vs),
        .i_Cam_Addr(cam_addr), .i_Cam_Data(cam_data), .i_Cam_WE(cam_we),
        .i_Rd_En(rd_en), .i_Rd_Addr(rd_addr), .i_Rd_Done(rd_done),
        .o_RAM_Addr(ram_addr), .o_RAM_Din(ram_din), .o_RAM_WE(ram_we), .i_RAM_Dout(ram_dout),
        .o_Rd_Data(rd_data), .o_Rd_Valid(rd_valid), .o_Frame_Valid(frame_valid),
        .o_Busy(busy), .o_Short_Frame(short_frame), .o_Frame_Count(frame_count)
    );

    frame_buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP_S), .RD_LATENCY(RDL)) dut_s (
        .i_Clk(clk), .i_Rst(rst), .i_Start(s_start), .i_Continuous(s_cont), .i_VS(s_vs),
        .i_Cam_Addr(s_addr), .i_Cam_Data(s_data), .i_Cam_WE(s_we),
        .i_Rd_En(1'b0), .i_Rd_Addr('0), .i_Rd_Done(s_done),
        .o_RAM_Addr(s_ram_addr), .o_RAM_Din(s_ram_din), .o_RAM_WE(s_ram_we), .i_RAM_Dout(8'h00),
        .o_Rd_Data(s_rd_data), .o_Rd_Valid(s_rd_valid), .o_Frame_Valid(s_fv),
        .o_Busy(s_busy), .o_Short_Frame(s_short), .o_Frame_Count(s_fc)
    );

    // Synchronous single-port RAM, one cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // ---------------- model and bookkeeping ----------------
    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0;
    int            m_phase, m_pix, m_fc, m_short, m_rv;
    logic [DW-1:0] m_mem [0:FP-1];
    int            q_due[$];
    int            q_dat[$];
    int            we_seen = 0, rv_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every read return must match the oldest outstanding accepted read, on its due cycle.
    always @(negedge clk) begin
        if (ram_we === 1'b1) we_seen++;
        if (rd_valid === 1'b1) begin
            rv_seen++;
            if (q_due.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_cycle", 32'(cyc), 32'(q_due.pop_front()));
                check("rd_data", 32'(rd_data), 32'(q_dat.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_busy"},  32'(busy),        32'(m_phase != P_IDLE));
        check({tag, "_fv"},    32'(frame_valid), 32'(m_phase == P_READY));
        check({tag, "_short"}, 32'(short_frame), 32'(m_short));
        check({tag, "_count"}, 32'(frame_count), 32'(m_fc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din",  32'(ram_din),  32'd0);
        check("rst_ram_we",   32'(ram_we),   32'd0);
        check("rst_rd_data",  32'(rd_data),  32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_fv",       32'(frame_valid), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_short",    32'(short_frame), 32'd0);
        check("rst_count",    32'(frame_count), 32'd0);
        rst     = 1'b0;
        m_phase = P_IDLE;
        m_pix   = 0;
        m_fc    = 0;
        m_short = 0;
        m_rv   -= q_due.size();
        q_due.delete();
        q_dat.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_we", 32'(ram_we), 32'd0);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        if (m_phase == P_IDLE) begin
            m_phase = P_WAIT;
            m_short = 0;
        end
        check_state("start");
    endtask

    // Drive the pad level; the controller acts on the edge four cycles later.
    task automatic vs_set(input logic v);
        logic edge_seen;
        edge_seen = (vs != v);
        vs = v;
        repeat (4) step();
        if (edge_seen && !v && m_phase == P_WAIT) begin
            m_phase = P_CAP;
            m_pix   = 0;
        end
        if (edge_seen && v && m_phase == P_CAP) begin
            m_phase = P_WAIT;
            m_short = 1;
        end
        check_state("vs");
    endtask

    task automatic cam_write(input int addr, input logic [DW-1:0] data);
        logic ok;
        ok       = (m_phase == P_CAP) && (addr < FP);
        cam_addr = AW'(addr);
        cam_data = data;
        cam_we   = 1'b1;
        step();
        cam_we = 1'b0;
        check("wr_we", 32'(ram_we), 32'(ok));
        if (ok) begin
            check("wr_addr", 32'(ram_addr), 32'(addr));
            check("wr_din",  32'(ram_din),  32'(data));
            m_mem[addr] = data;
            m_pix++;
            if (m_pix == FP) begin
                m_phase = P_READY;
                m_fc    = (m_fc + 1) % 256;
            end
        end
        check_state("wr");
    endtask

    // Pixels 0..n-1 in order, with random idle gaps and dropped out-of-range writes.
    task automatic write_frame(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(15, 0) == 0) idle(1);
            if ($urandom_range(31, 0) == 0) cam_write(int'($urandom_range((1 << AW) - 1, FP)), DW'($urandom));
            cam_write(i, DW'($urandom));
        end
    endtask

    task automatic rd_req(input int addr, input logic done, input logic c);
        logic acc;
        acc     = (m_phase == P_READY);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        rd_done = done;
        cont    = c;
        if (acc) begin
            q_due.push_back(cyc + 2 + RDL);
            q_dat.push_back(int'(m_mem[addr]));
            m_rv++;
        end
        step();
        rd_en   = 1'b0;
        rd_done = 1'b0;
        check("rd_we", 32'(ram_we), 32'd0);
        if (acc) check("rd_addr", 32'(ram_addr), 32'(addr));
        if (done && m_phase == P_READY) m_phase = c ? P_WAIT : P_IDLE;
        check_state("rd");
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3, 0) == 0) idle(1);
            rd_req(int'($urandom_range(FP - 1, 0)), 1'b0, cont);
        end
    endtask

    task automatic release_ram(input logic c);
        rd_done = 1'b1;
        cont    = c;
        step();
        rd_done = 1'b0;
        if (m_phase == P_READY) m_phase = c ? P_WAIT : P_IDLE;
        check_state("release");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_base;
        rst = 1'b1; start = 1'b0; cont = 1'b0; vs = 1'b1; cam_we = 1'b0;
        cam_addr = '0; cam_data = '0; rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
        s_start = 1'b0; s_cont = 1'b0; s_vs = 1'b1; s_we = 1'b0; s_addr = '0; s_data = '0; s_done = 1'b0;
        m_rv = 0;
        do_reset();
        idle(4);

        // Nothing is accepted before capture is armed and a frame has started.
        rd_req(5, 1'b0, 1'b0);
        cam_write(0, 8'hAA);
        vs_set(1'b0);
        vs_set(1'b1);
        start_pulse();
        start_pulse();
        cam_write(1, 8'h55);
        vs_set(1'b0);

        // Full frame, with the first out-of-range address probed explicitly.
        we_base = we_seen;
        cam_write(FP, 8'h11);
        write_frame(FP);
        idle(1);
        check("frame1_we_pulses", 32'(we_seen - we_base), 32'(FP));
        check("frame1_count", 32'(frame_count), 32'd1);

        // Owner is the reader now: camera writes and vsync edges are ignored.
        cam_write(3, 8'hEE);
        vs_set(1'b1);
        vs_set(1'b0);
        rd_req(0, 1'b0, 1'b0);
        rd_req(1, 1'b0, 1'b0);
        rd_req(FP - 1, 1'b0, 1'b0);
        random_reads(40);
        rd_req(int'($urandom_range(FP - 1, 0)), 1'b1, 1'b0);
        idle(6);
        check("drain_after_release", 32'(q_due.size()), 32'd0);

        // Short frame, then a full recapture; the short flag is sticky.
        start_pulse();
        vs_set(1'b1);
        vs_set(1'b0);
        write_frame(5000);
        vs_set(1'b1);
        check("short_set", 32'(short_frame), 32'd1);
        check("short_fv_low", 32'(frame_valid), 32'd0);
        vs_set(1'b0);
        write_frame(FP);
        check("frame2_count", 32'(frame_count), 32'd2);
        random_reads(20);
        release_ram(1'b0);
        start_pulse();
        check("start_clears_short", 32'(short_frame), 32'd0);

        // Reset in the middle of a capture, then a clean full frame.
        vs_set(1'b1);
        vs_set(1'b0);
        write_frame(3000);
        do_reset();
        start_pulse();
        vs_set(1'b1);
        vs_set(1'b0);
        write_frame(FP);
        check("after_reset_count", 32'(frame_count), 32'd1);
        random_reads(20);
        rd_req(FP - 1, 1'b1, 1'b0);
        idle(6);

        // 256 back-to-back frames in continuous mode on the small-frame instance.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int f = 0; f < 256; f++) begin
            s_vs = 1'b1;
            repeat (4) step();
            s_vs = 1'b0;
            repeat (4) step();
            for (int p = 0; p < FP_S; p++) begin
                s_we   = 1'b1;
                s_addr = AW'(p);
                s_data = DW'($urandom);
                step();
            end
            s_we = 1'b0;
            check("wrap_fv", 32'(s_fv), 32'd1);
            check("wrap_count", 32'(s_fc), 32'((f + 1) % 256));
            s_done = 1'b1;
            s_cont = 1'b1;
            step();
            s_done = 1'b0;
            check("wrap_rearm", 32'(s_busy && !s_fv), 32'd1);
        end
        check("wrap_zero", 32'(s_fc), 32'd0);

        check("rd_pending", 32'(q_due.size()), 32'd0);
        check("rd_total", 32'(rv_seen), 32'(m_rv));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
